// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t : responder FSM states (IDLE, WAIT, RESP)
//   LAT_W   : width of the access-latency wait counter
//   CNT_W   : width of the debug load/store counters
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned LAT_W = 4;
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM pipeline stage and the data memory.
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : request from the MEM stage
//   mem_ready : responder can accept a request this cycle
//   mem_ack   : one-cycle completion pulse; mem_rdata/mem_err valid with it
//   mem_busy  : transaction in flight (used by the MEM stage as a stall)
interface data_mem_responder_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        mem_busy;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ready, mem_ack, mem_rdata, mem_err, mem_busy
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ready, mem_ack, mem_rdata, mem_err, mem_busy
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port DEPTH x 32 word storage with per-byte write enables and a
// registered read port. Contents are never cleared.
//   clock : rising-edge clock
//   en    : access strobe (read always, write when we=1)
//   we    : write the bytes selected by be
//   addr  : word index
//   wdata : write data; be[i] selects bits 8i+7:8i
//   rdata : word at addr, registered on the access edge (pre-write contents)
module dmem_array #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic [3:0]           be,
    output logic [31:0]          rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM pipeline stage. Accepts one load/store
// at a time, waits LATENCY cycles, then commits the access and pulses
// mem_ack for one cycle. Misaligned or out-of-range addresses complete with
// mem_err=1 and no memory side effect.
//   clock       : rising-edge clock
//   reset       : synchronous, active-low
//   bus         : request/response bus (slave side)
//   load_count  : completed loads (including errored), wrapping
//   store_count : completed stores (including errored), wrapping
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_responder_if.slave bus,
    output logic [CNT_W-1:0]  load_count,
    output logic [CNT_W-1:0]  store_count
);

    localparam logic [LAT_W-1:0] WAIT_INIT = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

    state_t           state_q, state_d;
    logic [LAT_W-1:0] wait_q, wait_d;
    logic             err_q;
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] store_cnt_q;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;

    logic             txn_we;
    logic [31:0]      txn_addr;
    logic [31:0]      txn_wdata;
    logic [3:0]       txn_be;
    logic [31:0]      txn_offset;
    logic [31:0]      word_idx;
    logic             addr_err;
    logic             enter_resp;
    logic [31:0]      arr_rdata;

    // With LATENCY==0 the access commits on the acceptance edge, before the
    // capture registers hold the request, so in IDLE the live bus is used.
    assign txn_we     = (state_q == IDLE) ? bus.mem_we    : we_q;
    assign txn_addr   = (state_q == IDLE) ? bus.mem_addr  : addr_q;
    assign txn_wdata  = (state_q == IDLE) ? bus.mem_wdata : wdata_q;
    assign txn_be     = (state_q == IDLE) ? bus.mem_be    : be_q;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign txn_offset = txn_addr - BASE_ADDR;
    assign word_idx   = txn_offset >> 2;
    assign addr_err   = (txn_addr[1:0] != 2'b00) || (word_idx >= DEPTH);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side effects happen only on the edge that enters RESP, and never
    // while reset is asserted, so an aborted request leaves storage untouched.
    assign enter_resp = reset && (state_q != RESP) && (state_d == RESP);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (enter_resp) begin
                err_q <= addr_err;
                if (txn_we) begin
                    store_cnt_q <= store_cnt_q + CNT_W'(1);
                end else begin
                    load_cnt_q <= load_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.mem_req) begin
            we_q    <= bus.mem_we;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_be;
        end
    end

    dmem_array #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clock (clock),
        .en    (enter_resp),
        .we    (txn_we && !addr_err),
        .addr  (word_idx[ADDR_BITS-1:0]),
        .wdata (txn_wdata),
        .be    (txn_be),
        .rdata (arr_rdata)
    );

    assign bus.mem_ready = reset && (state_q == IDLE);
    assign bus.mem_busy  = (state_q != IDLE);
    assign bus.mem_ack   = (state_q == RESP);
    assign bus.mem_err   = (state_q == RESP) && err_q;
    assign bus.mem_rdata = (state_q == RESP && !err_q && !we_q) ? arr_rdata : '0;

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;

endmodule
